// File: rtl/fp_pkg.sv
// fp_pkg: FP constants, rounding modes, flag indices and scheduler states
package fp_pkg;
   localparam logic [2:0] RNE = 3'd0;
   localparam logic [2:0] RZ = 3'd1;
   localparam logic [2:0] RD = 3'd2;
   localparam logic [2:0] RU = 3'd3;
   localparam logic [2:0] RNA = 3'd4;
   localparam logic [31:0] FP_NANQ = 32'h7FC00000;
   localparam logic [31:0] FP_INFP = 32'h7F800000;
   localparam int FL_TO = 4;
   localparam int FL_INV = 3;
   localparam int FL_OV = 2;
   localparam int FL_UN = 1;
   localparam int FL_NX = 0;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   function automatic logic [2:0] sanitize_rm(input logic [2:0] rm);
      return (rm inside {RNE, RZ, RD, RU, RNA}) ? rm : RNE;
   endfunction
endpackage

// File: rtl/fp_sqr_sched_rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter scanning upward from ptr
module rr_arbiter #(
   parameter int N = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] idx,
   output logic           any
);
   always_comb begin
      gnt = '0;
      idx = '0;
      any = |req;
      // scan from farthest to nearest so the requester closest to ptr wins last
      for (int i = N - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % N]) begin
            gnt = '0;
            gnt[(int'(ptr) + i) % N] = 1'b1;
            idx = IDW'((int'(ptr) + i) % N);
         end
      end
   end
endmodule

// File: rtl/fp_sqr_sched.sv
// fp_sqr_sched: round-robin scheduler sharing one fp_sqr unit among N requesters
module fp_sqr_sched import fp_pkg::*; #(
   parameter int N = 4,
   parameter int IDW = 2,
   parameter int W = 32,
   parameter int TIMEOUT = 64,
   parameter int TW = 7
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req_valid,
   output logic [N-1:0]   req_ready,
   input  logic [N*W-1:0] req_data,
   input  logic [N*3-1:0] req_rm,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [IDW-1:0] rsp_id,
   output logic [W-1:0]   rsp_data,
   output logic [4:0]     rsp_flags,
   output logic [W-1:0]   sqr_in,
   output logic [2:0]     sqr_round_m,
   output logic           sqr_act,
   input  logic [W-1:0]   sqr_out,
   input  logic           sqr_ov,
   input  logic           sqr_un,
   input  logic           sqr_inv,
   input  logic           sqr_inexact,
   input  logic           sqr_done,
   output logic           busy
);
   localparam logic [4:0] TO_FLAGS = 5'((1 << FL_TO) | (1 << FL_INV));
   state_t state, state_n;
   logic [TW-1:0] cnt;
   logic [IDW-1:0] rr_ptr, gidx;
   logic [N-1:0] gnt;
   logic any, done_q, done_rise, timeout;
   assign done_rise = sqr_done & ~done_q;
   assign timeout = cnt == TW'(TIMEOUT - 1);
   rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
      .req(req_valid),
      .ptr(rr_ptr),
      .gnt(gnt),
      .idx(gidx),
      .any(any)
   );
   always_comb begin
      state_n = state;
      req_ready = '0;
      case (state)
         IDLE: begin
            state_n = any ? ISSUE : IDLE;
            req_ready = rst ? '0 : gnt;
         end
         ISSUE: state_n = WAIT;
         WAIT: state_n = (done_rise || timeout) ? RESP : WAIT;
         RESP: state_n = rsp_ready ? IDLE : RESP;
         default: state_n = IDLE;
      endcase
      sqr_act = state == ISSUE;
      rsp_valid = state == RESP;
      busy = state != IDLE;
   end
   // rsp_id doubles as the latched grant id: it only changes on accept
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rr_ptr <= '0;
         done_q <= 1'b0;
         cnt <= '0;
         rsp_id <= '0;
         sqr_in <= '0;
         sqr_round_m <= RNE;
         rsp_data <= '0;
         rsp_flags <= '0;
      end else begin
         state <= state_n;
         done_q <= sqr_done;
         cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
         if (state == IDLE && any) begin
            sqr_in <= req_data[int'(gidx)*W +: W];
            sqr_round_m <= sanitize_rm(req_rm[int'(gidx)*3 +: 3]);
            rsp_id <= gidx;
         end
         if (state == WAIT && (done_rise || timeout)) begin
            rsp_data <= done_rise ? sqr_out : W'(FP_NANQ);
            rsp_flags <= done_rise ? {1'b0, sqr_inv, sqr_ov, sqr_un, sqr_inexact} : TO_FLAGS;
         end
         if (state == RESP && rsp_ready) rr_ptr <= IDW'((int'(rsp_id) + 1) % N);
      end
   end
endmodule

// File: doc/fp_sqr_sched.md
Name: fp_sqr_sched

Overview:
- Shares one fp_sqr square-root unit among N requesters using a round-robin arbiter.
- Only one operation is in flight at a time.
- For each operation the block latches the operand and rounding mode, pulses the unit's act input, waits for done, then returns result, flags and requester ID on a valid/ready response port.
- It sits between the SoC-side request ports and the FP square-root datapath.

Parameters:
- N, 4, number of requesters.
- IDW, 2, requester-ID width; must satisfy 2**IDW >= N.
- W, 32, FP word width.
- TIMEOUT, 64, WAIT cycles allowed before the operation is aborted.
- TW, 7, timeout counter width; must hold TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N  per-requester request valid.
- req_ready  out  N  per-requester accept; one-hot or zero.
- req_data  in  N*W  operands; requester k uses bits [k*W +: W].
- req_rm  in  N*3  rounding modes; requester k uses bits [k*3 +: 3].
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  ID of the requester that owns the response.
- rsp_data  out  W  square-root result.
- rsp_flags  out  5  {timeout, inv, ov, un, inexact}.
- sqr_in  out  W  operand to fp_sqr.
- sqr_round_m  out  3  rounding mode to fp_sqr.
- sqr_act  out  1  one-cycle start pulse.
- sqr_out  in  W  fp_sqr result.
- sqr_ov, sqr_un, sqr_inv, sqr_inexact  in  1 each  fp_sqr flags.
- sqr_done  in  1  fp_sqr done.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: single clock, clk. rst is synchronous and active-high. Reset forces state=IDLE, rr_ptr=0, and drives every output to 0 (req_ready, rsp_*, sqr_in, sqr_round_m, sqr_act, busy). Reset asserted mid-operation abandons the in-flight operation; no response is produced for it.
- done_q register: holds sqr_done delayed by one cycle, updated every cycle; reset value 0. done_rise = sqr_done & ~done_q.
- IDLE:
  - Arbitration is combinational. Starting at rr_ptr and scanning upward modulo N, grant the first k with req_valid[k]=1.
  - req_ready[k]=1 for the granted requester only, in that same cycle.
  - The transfer occurs in that cycle. Latch op=req_data[k], rm=req_rm[k], gid=k, then go to ISSUE.
  - If no request is valid, stay in IDLE with req_ready=0.
- Rounding-mode sanitising: an rm code outside the five package modes (RNE, RZ, RD, RU, RNA) is latched as RNE.
- ISSUE (exactly 1 cycle): sqr_act=1, clear the wait counter, go to WAIT.
- sqr_in / sqr_round_m stability: both drive the latched values and stay stable from ISSUE until leaving WAIT.
- WAIT:
  - sqr_act=0; the counter increments each cycle.
  - On done_rise: capture rsp_data=sqr_out and rsp_flags={0, sqr_inv, sqr_ov, sqr_un, sqr_inexact}, then go to RESP.
  - If the counter reaches TIMEOUT-1 with no done_rise: capture rsp_data=0x7FC00000 and rsp_flags=5'b11000, then go to RESP.
  - If both occur in the same cycle, done_rise wins.
  - A sqr_done held high since before ISSUE is ignored; only a rising edge completes the operation.
- RESP:
  - rsp_valid=1 with rsp_id=gid.
  - rsp_id, rsp_data and rsp_flags are held stable until rsp_valid & rsp_ready.
  - On handshake: rsp_valid drops next cycle, rr_ptr=(gid+1) mod N, go to IDLE.
- No request is accepted outside IDLE; req_ready=0 in ISSUE, WAIT and RESP. The minimum gap between accepts is therefore 3 cycles plus the unit latency.
- Minimum latency: accept-to-rsp_valid is 2 + L cycles, where L is the cycle count from sqr_act to done_rise.
- Flags: the controller passes them through; it never alters inv/ov/un/inexact on the done path.

Decomposition:
- Shared package fp_pkg holds:
  - rounding-mode constants RNE, RZ, RD, RU, RNA;
  - FP_NANQ (0x7FC00000) and FP_INFP;
  - the state encoding IDLE/ISSUE/WAIT/RESP;
  - flag bit-index constants.
- One sub-module, rr_arbiter (N-way round-robin, inputs req and ptr, outputs a one-hot grant plus its index), is natural and reusable.
- The fp_sqr instance lives in the parent, not inside this block.

Test Plan:
- Single request: requester 2, operand 0x40800000 (4.0), rm=RNE, model latency 5 → req_ready[2] pulses once, sqr_act pulses once, rsp_valid with rsp_id=2, rsp_data=0x40000000, flags=0.
- Contention: all four requesters valid continuously, rsp_ready=1 → grants are serviced in order 0,1,2,3,0; no requester is skipped or repeated.
- Backpressure: rsp_ready=0 for 10 cycles during RESP → rsp outputs stay stable, req_ready stays 0; accepted exactly once when rsp_ready=1.
- Timeout: model never raises sqr_done → after TIMEOUT WAIT cycles, rsp_data=0x7FC00000, rsp_flags=5'b11000; the next request is then served normally.
- Stale done and bad mode: sqr_done held at 1 from before ISSUE, request with rm=3'b111 → no completion until a fresh rising edge; sqr_round_m equals RNE.
- Reset mid-WAIT: assert rst for 1 cycle → next cycle busy=0, all outputs 0, rr_ptr=0; no response is issued for the abandoned request.
